ahb_lite_cordic_bridge: RTL and testbench

AHB-Lite slave exposing a CORDIC core as a small register map, with a parametrised input FIFO, internal result FIFO and credit-based issue so results are never dropped. It sits between the AHB-Lite interconnect and the CORDIC datapath. It supersedes the single-register bridge by adding configurable width and depth, wait-state back-pressure, an error response, status reporting and a flush.

---
 rtl/ahb_cordic_pkg.sv | 40 ++++
 rtl/ahb_lite_cordic_bridge_fifo.sv | 61 ++++++
 rtl/ahb_lite_cordic_bridge.sv | 172 +++++++++++++++++
 tb/tb_ahb_lite_cordic_bridge.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_cordic_pkg.sv
// Shared constants for the AHB-Lite CORDIC bridge: register offsets, bus codes,
// STATUS field positions and the data-phase state encoding.
package ahb_cordic_pkg;

  localparam logic [1:0] REG_DATA_IN  = 2'd0;
  localparam logic [1:0] REG_DATA_OUT = 2'd1;
  localparam logic [1:0] REG_STATUS   = 2'd2;
  localparam logic [1:0] REG_CTRL     = 2'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam int STAT_IN_CNT    = 0;
  localparam int STAT_OUT_CNT   = 8;
  localparam int STAT_FLIGHT    = 16;
  localparam int STAT_IN_FULL   = 24;
  localparam int STAT_OUT_EMPTY = 25;

  typedef enum logic [2:0] {
    DP_IDLE,
    DP_WAIT_WR,
    DP_WAIT_RD,
    DP_ERR1,
    DP_ERR2
  } dphase_e;

  // Non-word sizes and accesses against a register's direction are rejected.
  function automatic logic is_bad_access(input logic wr, input logic [1:0] off,
                                         input logic [2:0] size);
    logic bad_dir;
    bad_dir = wr ? (off == REG_DATA_OUT || off == REG_STATUS)
                 : (off == REG_DATA_IN  || off == REG_CTRL);
    return (size != HSIZE_WORD) || bad_dir;
  endfunction

endpackage

// File: rtl/ahb_lite_cordic_bridge_fifo.sv
// Synchronous FIFO with occupancy count and a single-cycle flush.
// Flush wins over push/pop; push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH[AW:0]);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + {{AW{1'b0}}, 1'b1};
    else if (!do_push && do_pop) count_d = count_q - {{AW{1'b0}}, 1'b1};
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ahb_lite_cordic_bridge.sv
// AHB-Lite slave front-end for a CORDIC core: operand/result FIFOs, wait-state
// back-pressure, error responses and credit-based issue so no result is lost.
module ahb_lite_cordic_bridge
  import ahb_cordic_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic              HWRITE,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [31:0]       HRDATA,
  output logic [DATA_W-1:0] cordic_in_data,
  output logic              cordic_in_valid,
  input  logic              cordic_in_ready,
  input  logic [DATA_W-1:0] cordic_out_data,
  input  logic              cordic_out_valid
);
  localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
  localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

  dphase_e           state_q, state_d;
  logic [1:0]        addr_q, addr_d;
  logic              aphase;
  logic              in_push, out_pop, clear;
  logic              in_full, in_empty, out_full, out_empty;
  logic [IN_CW-1:0]  in_count;
  logic [OUT_CW-1:0] out_count;
  logic [DATA_W-1:0] out_dout;
  logic [31:0]       status;
  logic [OUT_CW-1:0] in_flight_q, in_flight_d, flight_nxt;
  logic [OUT_CW:0]   discard_q, discard_d, disc_nxt;
  logic [OUT_CW:0]   pending;
  logic              issue, out_push, res_drop;
  logic              unused_bits;

  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], out_full};
  assign aphase = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= DP_IDLE;
    else        state_q <= state_d;
    addr_q <= addr_d;
  end

  // ERR1 always falls through to ERR2; every other state advances on HREADY.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q == DP_ERR1) begin
      state_d = DP_ERR2;
    end else if (HREADY) begin
      if (aphase) begin
        addr_d = HADDR[3:2];
        if (is_bad_access(HWRITE, HADDR[3:2], HSIZE)) state_d = DP_ERR1;
        else if (HWRITE)                              state_d = DP_WAIT_WR;
        else                                          state_d = DP_WAIT_RD;
      end else begin
        state_d = DP_IDLE;
      end
    end
  end

  always_comb begin
    status = '0;
    status[STAT_IN_CNT  +: 8] = 8'(in_count);
    status[STAT_OUT_CNT +: 8] = 8'(out_count);
    status[STAT_FLIGHT  +: 8] = 8'(in_flight_q);
    status[STAT_IN_FULL]      = in_full;
    status[STAT_OUT_EMPTY]    = out_empty;
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    in_push   = 1'b0;
    out_pop   = 1'b0;
    clear     = 1'b0;
    unique case (state_q)
      DP_WAIT_WR: begin
        if (addr_q == REG_DATA_IN) begin
          HREADYOUT = !in_full;
          in_push   = !in_full;
        end else begin
          clear = HWDATA[0];
        end
      end
      DP_WAIT_RD: begin
        if (addr_q == REG_DATA_OUT) begin
          HREADYOUT = !out_empty;
          out_pop   = !out_empty;
          if (!out_empty) HRDATA[DATA_W-1:0] = out_dout;
        end else begin
          HRDATA = status;
        end
      end
      DP_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      DP_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  // Credits cover every result that could still land in the result FIFO.
  assign pending         = {1'b0, in_flight_q} + {1'b0, out_count};
  assign cordic_in_valid = !in_empty && (pending < OUT_DEPTH[OUT_CW:0]);
  assign issue           = cordic_in_valid && cordic_in_ready;
  assign res_drop        = cordic_out_valid && (discard_q != '0);
  assign out_push        = cordic_out_valid && (discard_q == '0);

  always_comb begin
    flight_nxt = in_flight_q;
    if (issue && !out_push)      flight_nxt = in_flight_q + {{(OUT_CW-1){1'b0}}, 1'b1};
    else if (!issue && out_push) flight_nxt = in_flight_q - {{(OUT_CW-1){1'b0}}, 1'b1};
    disc_nxt    = res_drop ? discard_q - {{OUT_CW{1'b0}}, 1'b1} : discard_q;
    in_flight_d = flight_nxt;
    discard_d   = disc_nxt;
    if (clear) begin
      discard_d   = disc_nxt + {1'b0, flight_nxt};
      in_flight_d = '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      in_flight_q <= '0;
      discard_q   <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      discard_q   <= discard_d;
    end
  end

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .push_i  (in_push),
    .pop_i   (issue),
    .flush_i (clear),
    .din_i   (HWDATA[DATA_W-1:0]),
    .dout_o  (cordic_in_data),
    .count_o (in_count),
    .full_o  (in_full),
    .empty_o (in_empty)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .push_i  (out_push),
    .pop_i   (out_pop),
    .flush_i (clear),
    .din_i   (cordic_out_data),
    .dout_o  (out_dout),
    .count_o (out_count),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

endmodule

// File: tb/tb_ahb_lite_cordic_bridge.sv
// Directed bench for the AHB-Lite CORDIC bridge (IN_DEPTH=4, OUT_DEPTH=4).
module tb_ahb_lite_cordic_bridge;
  import ahb_cordic_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HREADY, HWRITE;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic [2:0]  HSIZE;
  logic        HREADYOUT;
  logic [31:0] cordic_in_data, cordic_out_data;
  logic        cordic_in_valid, cordic_in_ready, cordic_out_valid;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] issued [$];
  logic [31:0] exp_ops [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_lite_cordic_bridge #(.DATA_W(32), .IN_DEPTH(4), .OUT_DEPTH(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .cordic_in_data(cordic_in_data), .cordic_in_valid(cordic_in_valid),
    .cordic_in_ready(cordic_in_ready), .cordic_out_data(cordic_out_data),
    .cordic_out_valid(cordic_out_valid)
  );

  always @(negedge HCLK) begin
    if (!HRESET && cordic_in_valid && cordic_in_ready) issued.push_back(cordic_in_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00;
    end
    #1;
  endtask

  // rel: data-phase cycle at which the core starts accepting operands (-1: never)
  task automatic ahb_wr(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size,
                        input int rel, output int waits, output logic [1:0] resp0,
                        output logic [1:0] resp);
    bit done = 1'b0;
    waits = 0; resp0 = 2'b11; resp = 2'b11;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = addr; HSIZE = size;
    for (int i = 0; i < 64 && !done; i++) begin
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = data;
      if (i == rel) cordic_in_ready = 1'b1;
      #1;
      if (i == 0) resp0 = HRESP;
      if (HREADYOUT) begin done = 1'b1; resp = HRESP; end
      else waits++;
    end
  endtask

  // inj: data-phase cycle in which the core returns inj_data (-1: never)
  task automatic ahb_rd(input logic [31:0] addr, input logic [2:0] size, input int inj,
                        input logic [31:0] inj_data, output logic [31:0] rdata,
                        output int waits, output logic [1:0] resp);
    bit done = 1'b0;
    waits = 0; rdata = 32'hDEAD_BEEF; resp = 2'b11;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = addr; HSIZE = size;
    for (int i = 0; i < 64 && !done; i++) begin
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00;
      cordic_out_valid = (i == inj); cordic_out_data = inj_data;
      #1;
      if (HREADYOUT) begin done = 1'b1; rdata = HRDATA; resp = HRESP; end
      else waits++;
    end
    cordic_out_valid = 1'b0;
  endtask

  task automatic push_result(input logic [31:0] d);
    @(posedge HCLK); #1;
    cordic_out_valid = 1'b1; cordic_out_data = d;
    @(posedge HCLK); #1;
    cordic_out_valid = 1'b0;
  endtask

  task automatic rd_status(input string tag, input logic [31:0] exp);
    logic [31:0] d; int w; logic [1:0] r;
    ahb_rd(32'h8, HSIZE_WORD, -1, 32'h0, d, w, r);
    check({tag, "_wait"}, 32'(w), 32'd0);
    check(tag, d, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    logic [1:0] r0, r;
    logic [31:0] d;
    HRESET = 1'b1; HSEL = 1'b0; HWRITE = 1'b0; HADDR = '0; HTRANS = 2'b00;
    HSIZE = HSIZE_WORD; HWDATA = '0; cordic_in_ready = 1'b0;
    cordic_out_valid = 1'b0; cordic_out_data = '0;
    repeat (3) @(posedge HCLK);
    #1; HRESET = 1'b0; #1;
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_in_valid", 32'(cordic_in_valid), 32'd0);
    rd_status("rst_status", 32'h0200_0000);

    // single operand: issued the cycle after the write completes
    cordic_in_ready = 1'b1;
    ahb_wr(32'h0, 32'h0000_1234, HSIZE_WORD, -1, w, r0, r);
    check("wr1_wait", 32'(w), 32'd0);
    check("wr1_resp", 32'(r), 32'd0);
    idle(1);
    check("wr1_in_valid", 32'(cordic_in_valid), 32'd1);
    check("wr1_in_data", cordic_in_data, 32'h0000_1234);
    rd_status("wr1_status", 32'h0201_0000);
    cordic_in_ready = 1'b0;

    // read of empty result FIFO; result arrives in the 7th stalled cycle
    ahb_rd(32'h4, HSIZE_WORD, 6, 32'h0000_ABCD, d, w, r);
    check("rd_stall_wait", 32'(w), 32'd7);
    check("rd_stall_data", d, 32'h0000_ABCD);
    check("rd_stall_resp", 32'(r), 32'd0);
    rd_status("rd_stall_status", 32'h0200_0000);

    // fill the input FIFO with the core stalled, fifth write waits for a slot
    issued.delete();
    for (int i = 0; i < 4; i++) begin
      ahb_wr(32'h0, exp_ops[i], HSIZE_WORD, -1, w, r0, r);
      check("fill_wait", 32'(w), 32'd0);
    end
    rd_status("full_status", 32'h0300_0004);
    ahb_wr(32'h0, exp_ops[4], HSIZE_WORD, 3, w, r0, r);
    check("full_wr_wait", 32'(w), 32'd4);
    idle(4);
    check("credit_block_valid", 32'(cordic_in_valid), 32'd0);
    check("credit_issued_4", 32'(issued.size()), 32'd4);
    rd_status("credit_status", 32'h0204_0001);
    push_result(32'h0000_00A1);
    idle(2);
    check("credit_still_block", 32'(cordic_in_valid), 32'd0);
    rd_status("credit_status2", 32'h0003_0101);
    ahb_rd(32'h4, HSIZE_WORD, -1, 32'h0, d, w, r);
    check("credit_rd_wait", 32'(w), 32'd0);
    check("credit_rd_data", d, 32'h0000_00A1);
    idle(2);
    check("issued_5", 32'(issued.size()), 32'd5);
    for (int i = 0; i < 5; i++) check("issue_order", (i < issued.size()) ? issued[i] : 32'hX, exp_ops[i]);

    // CLEAR with three in flight: their results are discarded
    push_result(32'h0000_00B0);
    ahb_wr(32'hC, 32'h0000_0001, HSIZE_WORD, -1, w, r0, r);
    check("clear_wait", 32'(w), 32'd0);
    rd_status("clear_status", 32'h0200_0000);
    ahb_wr(32'h0, 32'h0000_0066, HSIZE_WORD, -1, w, r0, r);
    push_result(32'h0000_00D1);
    push_result(32'h0000_00D2);
    push_result(32'h0000_00D3);
    rd_status("drop_status", 32'h0201_0000);
    push_result(32'h0000_00D4);
    rd_status("keep_status", 32'h0000_0100);
    ahb_rd(32'h4, HSIZE_WORD, -1, 32'h0, d, w, r);
    check("keep_data", d, 32'h0000_00D4);

    // error responses
    ahb_wr(32'h0, 32'h0000_0077, 3'b000, -1, w, r0, r);
    check("err_byte_wait", 32'(w), 32'd1);
    check("err_byte_resp0", 32'(r0), 32'(HRESP_ERROR));
    check("err_byte_resp1", 32'(r), 32'(HRESP_ERROR));
    rd_status("err_byte_status", 32'h0200_0000);
    ahb_wr(32'h8, 32'h0000_0001, HSIZE_WORD, -1, w, r0, r);
    check("err_wr_status_wait", 32'(w), 32'd1);
    check("err_wr_status_resp", 32'(r), 32'(HRESP_ERROR));
    ahb_rd(32'h0, HSIZE_WORD, -1, 32'h0, d, w, r);
    check("err_rd_in_wait", 32'(w), 32'd1);
    check("err_rd_in_resp", 32'(r), 32'(HRESP_ERROR));
    check("err_rd_in_data", d, 32'h0);

    // reset while a read is stalled abandons the transfer
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = 32'h4; HSIZE = HSIZE_WORD;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; #1;
    check("stall_before_rst", 32'(HREADYOUT), 32'd0);
    @(posedge HCLK); #1; HRESET = 1'b1;
    @(posedge HCLK); #1; HRESET = 1'b0; #1;
    check("rst_mid_stall_rdy", 32'(HREADYOUT), 32'd1);
    check("rst_mid_stall_resp", 32'(HRESP), 32'd0);
    rd_status("post_rst_status", 32'h0200_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
